// File: rtl/codificador_pkg.sv
// Shared types and constants for the RV64I instruction encoder.
// The optional range/alignment check is enabled by defining CODIF_RANGE_CHECK_EN.
package codificador_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } formato_t;

    // addi x0, x0, 0 -- substituted whenever the request cannot be encoded
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Representable immediate ranges (bytes, unscaled)
    localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM12_MAX =  64'sd2047;
    localparam logic signed [63:0] IMM_B_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM_B_MAX =  64'sd4094;
    localparam logic signed [63:0] IMM_J_MIN = -64'sd1048576;
    localparam logic signed [63:0] IMM_J_MAX =  64'sd1048574;
    localparam logic signed [63:0] IMM_U_MIN = -64'sd2147483648;
    localparam logic signed [63:0] IMM_U_MAX =  64'sd2147483647;

    // True when imm can be encoded exactly in the given format.
    // R and illegal formats report true; illegal formats are flagged separately.
    function automatic logic imm_fits(input logic [2:0] fmt, input logic [63:0] imm);
        logic signed [63:0] v;
        logic ok;
        v = imm;
        case (fmt)
            FMT_I, FMT_S: ok = (v >= IMM12_MIN) && (v <= IMM12_MAX);
            FMT_B:        ok = (v >= IMM_B_MIN) && (v <= IMM_B_MAX) && (imm[0] == 1'b0);
            FMT_U:        ok = (v >= IMM_U_MIN) && (v <= IMM_U_MAX) && (imm[11:0] == 12'd0);
            FMT_J:        ok = (v >= IMM_J_MIN) && (v <= IMM_J_MAX) && (imm[0] == 1'b0);
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/codificador_instr_empaquetador.sv
// Purely combinational scatter of register/function fields and immediate bits
// into a 32-bit RV64I instruction word.
module empaquetador_imm
    import codificador_pkg::*;
(
    input  logic [2:0]  formato,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr
);

    // Field placement per instruction format; illegal formats yield the NOP
    always_comb begin
        instr = NOP_INSTR;
        case (formato)
            FMT_R:   instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   instr = {imm[31:12], rd, opcode};
            FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: instr = NOP_INSTR;
        endcase
    end

endmodule

// File: rtl/codificador_instr.sv
// RV64I instruction encoder: two-stage valid/ready pipeline.
// S1 captures the fields and the error verdict, S2 captures the packed word.
// Define CODIF_RANGE_CHECK_EN to reject immediates that do not fit the format.
module codificador_instr
    import codificador_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Formato,
    input  logic [6:0]       Opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [63:0]      Inmediato,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      Instruccion,
    output logic             Error,
    output logic [CNT_W-1:0] Contador
);

    logic             s1_valid_r;
    logic [2:0]       s1_fmt_r;
    logic [6:0]       s1_opcode_r;
    logic [4:0]       s1_rd_r;
    logic [4:0]       s1_rs1_r;
    logic [4:0]       s1_rs2_r;
    logic [2:0]       s1_funct3_r;
    logic [6:0]       s1_funct7_r;
    logic [31:0]      s1_imm_r;
    logic             s1_err_r;

    logic             s2_valid_r;
    logic [31:0]      s2_word_r;
    logic             s2_err_r;
    logic [CNT_W-1:0] contador_r;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             fmt_legal_s;
    logic             in_err_s;
    logic [31:0]      packed_s;
    logic [31:0]      s2_word_next_s;

    assign s2_adv_s    = !s2_valid_r || out_ready;
    assign s1_adv_s    = !s1_valid_r || s2_adv_s;
    assign in_ready    = s1_adv_s;
    assign fmt_legal_s = (Formato <= 3'd5);

`ifdef CODIF_RANGE_CHECK_EN
    assign in_err_s = !fmt_legal_s || !imm_fits(Formato, Inmediato);
`else
    // Upper immediate bits are simply truncated when no checking is done
    logic imm_hi_unused_s;
    assign imm_hi_unused_s = ^Inmediato[63:32];
    assign in_err_s        = !fmt_legal_s;
`endif

    // Stage 1: capture fields and error verdict on an accepted input
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_fmt_r    <= 3'd0;
            s1_opcode_r <= 7'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_funct3_r <= 3'd0;
            s1_funct7_r <= 7'd0;
            s1_imm_r    <= 32'd0;
            s1_err_r    <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_fmt_r    <= Formato;
                s1_opcode_r <= Opcode;
                s1_rd_r     <= rd;
                s1_rs1_r    <= rs1;
                s1_rs2_r    <= rs2;
                s1_funct3_r <= funct3;
                s1_funct7_r <= funct7;
                s1_imm_r    <= Inmediato[31:0];
                s1_err_r    <= in_err_s;
            end
        end
    end

    empaquetador_imm u_empaquetador (
        .formato (s1_fmt_r),
        .opcode  (s1_opcode_r),
        .rd      (s1_rd_r),
        .rs1     (s1_rs1_r),
        .rs2     (s1_rs2_r),
        .funct3  (s1_funct3_r),
        .funct7  (s1_funct7_r),
        .imm     (s1_imm_r),
        .instr   (packed_s)
    );

    // Substitute the canonical NOP for any word flagged as unencodable
    always_comb begin
        s2_word_next_s = packed_s;
        if (s1_err_r) begin
            s2_word_next_s = NOP_INSTR;
        end else begin
            s2_word_next_s = packed_s;
        end
    end

    // Stage 2: hold the outgoing word until the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_word_r  <= 32'd0;
            s2_err_r   <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_word_r <= s2_word_next_s;
                s2_err_r  <= s1_err_r;
            end
        end
    end

    // Count completed output transfers, wrapping naturally; reset has priority
    always_ff @(posedge clk) begin
        if (reset) begin
            contador_r <= '0;
        end else if (s2_valid_r && out_ready) begin
            contador_r <= contador_r + CNT_W'(1);
        end else begin
            contador_r <= contador_r;
        end
    end

    assign out_valid   = s2_valid_r;
    assign Instruccion = s2_word_r;
    assign Error       = s2_err_r;
    assign Contador    = contador_r;

endmodule
